// File: rtl/key_debounce_multi_if.sv
// Key debouncer bus: raw pins in, per-channel debounced level and event pulses out.
//   key         : raw asynchronous key pins (driven by the board side / master)
//   key_level   : debounced level, 1 = pressed
//   key_press   : one-cycle pulse on debounced released->pressed
//   key_release : one-cycle pulse on debounced pressed->released
//   key_long    : one-cycle long-press pulse (0 when the long-press feature is absent)
interface key_debounce_multi_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;

  modport master (
    output key,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer.
// Each of NUM_KEYS raw pins is synchronised by two flops and then debounced independently:
// a level change is accepted only after CNT_MAX consecutive cycles at the new level.
// Outputs per channel: debounced active-high level, press/release pulses and an optional
// long-press pulse.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : key_debounce_multi_if.slave (key in; key_level/key_press/key_release/key_long out)
//
// Build option: define KEY_LONG_PRESS_EN to add a per-channel long-press counter; without it
// key_long is tied to 0 and no long counters exist.
module key_debounce_multi #(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned CNT_W          = 19,
  parameter int unsigned CNT_MAX        = 500000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter int unsigned LONG_W         = 27,
  parameter int unsigned LONG_MAX       = 100000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  key_debounce_multi_if.slave      bus
);

  // Synchroniser reset value: the pin level of a released key.
  localparam logic [NUM_KEYS-1:0] RelPins = {NUM_KEYS{KEY_ACTIVE_LOW}};
  localparam logic [CNT_W-1:0]    CntLast = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 2 || NUM_KEYS < 1 || CNT_W < 1 || LONG_MAX < 2 || LONG_W < 1) begin : g_bad_params
    $error("key_debounce_multi: illegal parameter configuration");
  end

  logic [NUM_KEYS-1:0] s1_q, s2_q;
  logic [NUM_KEYS-1:0] s2_pressed;
  // stable_q holds the accepted level already converted to active-high (1 = pressed).
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;

  assign s2_pressed = KEY_ACTIVE_LOW ? ~s2_q : s2_q;

  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      // Default clears the count, so any bounce back to the stable level restarts it.
      cnt_d[i] = '0;
      if (s2_pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i]  = s2_pressed[i];
          press_d[i]   = s2_pressed[i];
          release_d[i] = ~s2_pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= RelPins;
      s2_q      <= RelPins;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= bus.key;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.key_level   = stable_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LongLast = LONG_W'(LONG_MAX - 1);
  localparam logic [LONG_W-1:0] LongPrev = LONG_W'(LONG_MAX - 2);

  logic [LONG_W-1:0]   long_cnt_q [NUM_KEYS];
  logic [LONG_W-1:0]   long_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_q, long_d;

  always_comb begin
    long_d = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      long_cnt_d[i] = '0;
      if (stable_q[i]) begin
        if (long_cnt_q[i] == LongLast) begin
          // Saturated: holds here so the pulse cannot repeat within one press.
          long_cnt_d[i] = long_cnt_q[i];
        end else begin
          long_cnt_d[i] = long_cnt_q[i] + LONG_W'(1);
          long_d[i]     = (long_cnt_q[i] == LongPrev);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        long_cnt_q[i] <= '0;
      end
    end else begin
      long_q <= long_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        long_cnt_q[i] <= long_cnt_d[i];
      end
    end
  end

  assign bus.key_long = long_q;
`else
  assign bus.key_long = '0;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: NUM_KEYS=4, CNT_MAX=8, LONG_MAX=20, active-low pins.
module tb_key_debounce_multi;

  localparam int unsigned NK = 4;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_debounce_multi_if #(.NUM_KEYS(NK)) bus ();

  key_debounce_multi #(
    .NUM_KEYS       (NK),
    .CNT_W          (4),
    .CNT_MAX        (8),
    .KEY_ACTIVE_LOW (1'b1),
    .LONG_W         (8),
    .LONG_MAX       (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse tallies, sampled on the falling edge.
  int press_cnt [NK];
  int rel_cnt   [NK];
  int long_cnt  [NK];
  int both_cnt  = 0;

  always @(negedge clk) begin
    for (int i = 0; i < int'(NK); i++) begin
      if (bus.key_press[i] === 1'b1) press_cnt[i]++;
      if (bus.key_release[i] === 1'b1) rel_cnt[i]++;
      if (bus.key_long[i] === 1'b1) long_cnt[i]++;
      if (bus.key_press[i] === 1'b1 && bus.key_release[i] === 1'b1) both_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [3:0] lng);
    chk({name, "_level"},   32'(bus.key_level),   32'(lvl));
    chk({name, "_press"},   32'(bus.key_press),   32'(prs));
    chk({name, "_release"}, 32'(bus.key_release), 32'(rel));
    chk({name, "_long"},    32'(bus.key_long),    32'(lng));
  endtask

  typedef struct {
    logic [3:0] key;
    int         edges;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs [8];
  int   rel_before;
  logic [3:0] long_exp;

  initial begin
    // Key 0 clean press and release; press/release land 10 edges after the pin change.
    vecs[0] = '{4'hF, 50, 4'h0, 4'h0, 4'h0};
    vecs[1] = '{4'hE,  9, 4'h0, 4'h0, 4'h0};
    vecs[2] = '{4'hE,  1, 4'h1, 4'h1, 4'h0};
    vecs[3] = '{4'hE,  1, 4'h1, 4'h0, 4'h0};
    vecs[4] = '{4'hE,  5, 4'h1, 4'h0, 4'h0};
    vecs[5] = '{4'hF,  9, 4'h1, 4'h0, 4'h0};
    vecs[6] = '{4'hF,  1, 4'h0, 4'h0, 4'h1};
    vecs[7] = '{4'hF,  1, 4'h0, 4'h0, 4'h0};
    long_exp = LongEn ? 4'h9 : 4'h0;

    rst_n   = 1'b0;
    bus.key = 4'hF;
    tick(3);
    chk_out("reset", 4'h0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      bus.key = vecs[v].key;
      tick(vecs[v].edges);
      chk_out($sformatf("vec%0d", v), vecs[v].level, vecs[v].press, vecs[v].rel, 4'h0);
    end
    chk("k0_press_count", 32'(press_cnt[0]), 32'd1);
    chk("k0_release_count", 32'(rel_cnt[0]), 32'd1);

    // Key 1 bounces in 3-cycle segments, then holds pressed.
    for (int seg = 0; seg < 10; seg++) begin
      bus.key[1] = seg[0];
      tick(3);
      chk($sformatf("bounce_level_%0d", seg), 32'(bus.key_level), 32'h0);
    end
    chk("bounce_press_count", 32'(press_cnt[1]), 32'd0);
    bus.key[1] = 1'b0;
    tick(9);
    chk_out("bounce_hold9", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_out("bounce_hold10", 4'h2, 4'h2, 4'h0, 4'h0);
    bus.key = 4'hF;
    tick(12);
    chk("bounce_rel_level", 32'(bus.key_level), 32'h0);
    chk("k1_press_count", 32'(press_cnt[1]), 32'd1);
    chk("k1_release_count", 32'(rel_cnt[1]), 32'd1);

    // Key 2: 7-cycle glitch rejected, 8-cycle glitch accepted.
    bus.key = 4'hB;
    tick(7);
    bus.key = 4'hF;
    tick(20);
    chk("glitch7_level", 32'(bus.key_level), 32'h0);
    chk("glitch7_press_count", 32'(press_cnt[2]), 32'd0);
    bus.key = 4'hB;
    tick(8);
    bus.key = 4'hF;
    tick(2);
    chk_out("glitch8_accept", 4'h4, 4'h4, 4'h0, 4'h0);
    tick(10);
    chk("glitch8_rel_level", 32'(bus.key_level), 32'h0);
    chk("glitch8_release_count", 32'(rel_cnt[2]), 32'd1);

    // Keys 0 and 3 together, then reset while held.
    bus.key = 4'h6;
    tick(9);
    chk_out("dual_pre", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_out("dual_press", 4'h9, 4'h9, 4'h0, 4'h0);
    tick(3);
    rel_before = rel_cnt[0] + rel_cnt[3];
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(3);
    rst_n = 1'b1;
    tick(9);
    chk_out("post_reset_pre", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset_no_release", 32'(rel_cnt[0] + rel_cnt[3]), 32'(rel_before));
    tick(1);
    chk_out("post_reset_press", 4'h9, 4'h9, 4'h0, 4'h0);

    // Long press: pulse on the 20th cycle of key_level high.
    tick(18);
    chk_out("long_pre", 4'h9, 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_out("long_fire", 4'h9, 4'h0, 4'h0, long_exp);
    tick(1);
    chk_out("long_after", 4'h9, 4'h0, 4'h0, 4'h0);
    tick(30);
    chk("long_count_k0", 32'(long_cnt[0]), LongEn ? 32'd1 : 32'd0);
    chk("long_count_k3", 32'(long_cnt[3]), LongEn ? 32'd1 : 32'd0);
    bus.key = 4'hF;
    tick(12);
    chk("long_rel_level", 32'(bus.key_level), 32'h0);
    bus.key = 4'hE;
    tick(10);
    chk_out("repress", 4'h1, 4'h1, 4'h0, 4'h0);
    tick(19);
    chk_out("long_refire", 4'h1, 4'h0, 4'h0, LongEn ? 4'h1 : 4'h0);
    tick(5);
    chk("long_count_k0_final", 32'(long_cnt[0]), LongEn ? 32'd2 : 32'd0);
    chk("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
